serial_subtractor: RTL

Bit-serial full subtractor computing d = a - b - bin over WIDTH bits, one bit per clock, LSB first. It is the inverse-operation counterpart of the team's combinational full adder cell and reuses the same single-bit sum/carry-style logic, here as difference/borrow. Operands are captured on a start handshake and shifted through internally. Result and borrow-out are presented with a one-cycle done pulse. It serves as a small-area arithmetic unit in datapaths where latency is acceptable.

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_full_sub_cell.sv | 13 +
 rtl/serial_subtractor.sv | 86 ++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_subtractor_full_sub_cell.sv
// Combinational 1-bit full subtractor; the difference/borrow dual of the full adder cell.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic r,
  output logic diff,
  output logic bnext
);

  assign diff  = x ^ y ^ r;
  assign bnext = (~x & y) | (~(x ^ y) & r);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b - bin, one bit per clock, LSB first.
//   state | meaning
//   IDLE  | waiting for start; d/bout hold the last result
//   RUN   | one operand bit pair processed per edge
//   DONE  | one-cycle done pulse; d/bout valid
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             diff_bit;
  logic             borrow_next;

  full_sub_cell u_cell (
    .x     (sa[0]),
    .y     (sb[0]),
    .r     (brw),
    .diff  (diff_bit),
    .bnext (borrow_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      sa     <= '0;
      sb     <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            brw   <= bin;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Difference bits enter at the MSB so bit 0 lands at d[0] after WIDTH shifts.
          d_q <= {diff_bit, d_q[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          brw <= borrow_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bout_q <= borrow_next;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign d    = d_q;
  assign bout = bout_q;

endmodule
